fc_feat_streamer: RTL and testbench

//  Producer side of the FC input interface. Buffers one frame of N_POS x N_CH feature words

---
 rtl/fc_feat_streamer.sv | 236 +++++++++++++++++++++++
 tb/tb_fc_feat_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_feat_streamer.sv
// fc_feat_streamer
// Collects one frame of N_POS x N_CH feature words (position-major, channel-minor)
// into four channel-interleaved banks. Once the frame is complete, it streams the
// frame to the FC MAC array as 4-lane beats, one channel group per beat.
// The stream has no stall path. Each output is a flop, so the read-data register
// of the banks is itself the lane register.
module fc_feat_streamer #(
    parameter int FEAT_W = 32,
    parameter int N_POS  = 169,
    parameter int N_CH   = 16
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iInValid,
    input  logic [FEAT_W-1:0] iInData,
    output logic              oInReady,
    output logic              oFrameStart,
    output logic [3:0]        oValid4,
    output logic [FEAT_W-1:0] oData0,
    output logic [FEAT_W-1:0] oData1,
    output logic [FEAT_W-1:0] oData2,
    output logic [FEAT_W-1:0] oData3,
    output logic [1:0]        oPhase_g,
    output logic              oBusy,
    output logic              oDone
);

    localparam int N_GRP  = N_CH / 4;
    localparam int DEPTH  = N_POS * N_GRP;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W   = $clog2(N_CH);
    localparam int POS_W  = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int G_W    = (N_GRP > 1) ? $clog2(N_GRP) : 1;

    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_POS - 1);
    localparam logic [G_W-1:0]    GRP_LAST = G_W'(N_GRP - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_START  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Feature storage: bank b holds channels with ch[1:0] == b
    logic [FEAT_W-1:0] bank_mem [4][DEPTH];

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_w_q, ch_w_d;
    logic [POS_W-1:0]  p_w_q, p_w_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [G_W-1:0]    g_r_q, g_r_d;
    logic [POS_W-1:0]  p_r_q, p_r_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic              in_ready_q, in_ready_d;
    logic              frame_start_q, frame_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [1:0]        phase_q, phase_d;
    logic [FEAT_W-1:0] data0_q, data0_d;
    logic [FEAT_W-1:0] data1_q, data1_d;
    logic [FEAT_W-1:0] data2_q, data2_d;
    logic [FEAT_W-1:0] data3_q, data3_d;

    logic wr_en_s;
    logic wr_last_s;
    logic rd_issue_s;
    logic rd_last_s;

    assign wr_en_s    = iInValid && in_ready_q;
    assign wr_last_s  = (p_w_q == POS_LAST) && (ch_w_q == CH_LAST);
    assign rd_issue_s = (state_q == ST_START) || (state_q == ST_STREAM);
    assign rd_last_s  = (p_r_q == POS_LAST) && (g_r_q == GRP_LAST);

    // Next-state and counter update: fill counters while collecting, read counters while streaming
    always_comb begin
        state_d   = state_q;
        ch_w_d    = ch_w_q;
        p_w_d     = p_w_q;
        wr_addr_d = wr_addr_q;
        g_r_d     = g_r_q;
        p_r_d     = p_r_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (wr_en_s) begin
                    if (ch_w_q == CH_LAST) begin
                        ch_w_d = {CH_W{1'b0}};
                        if (p_w_q == POS_LAST) begin
                            p_w_d = {POS_W{1'b0}};
                        end else begin
                            p_w_d = p_w_q + POS_W'(1'b1);
                        end
                    end else begin
                        ch_w_d = ch_w_q + CH_W'(1'b1);
                        p_w_d  = p_w_q;
                    end
                    // A bank row is complete once lane 3 of the group is written
                    if (ch_w_q[1:0] == 2'b11) begin
                        if (wr_last_s) begin
                            wr_addr_d = {ADDR_W{1'b0}};
                        end else begin
                            wr_addr_d = wr_addr_q + ADDR_W'(1'b1);
                        end
                    end else begin
                        wr_addr_d = wr_addr_q;
                    end
                    if (wr_last_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_START, ST_STREAM: begin
                if (rd_last_s) begin
                    g_r_d     = {G_W{1'b0}};
                    p_r_d     = {POS_W{1'b0}};
                    rd_addr_d = {ADDR_W{1'b0}};
                    state_d   = ST_DRAIN;
                end else begin
                    if (g_r_q == GRP_LAST) begin
                        g_r_d = {G_W{1'b0}};
                        p_r_d = p_r_q + POS_W'(1'b1);
                    end else begin
                        g_r_d = g_r_q + G_W'(1'b1);
                        p_r_d = p_r_q;
                    end
                    rd_addr_d = rd_addr_q + ADDR_W'(1'b1);
                    state_d   = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ch_w_d    = {CH_W{1'b0}};
                p_w_d     = {POS_W{1'b0}};
                wr_addr_d = {ADDR_W{1'b0}};
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values: status from the upcoming state, lanes from this cycle's read
    always_comb begin
        in_ready_d    = (state_d == ST_IDLE) || (state_d == ST_FILL);
        frame_start_d = (state_d == ST_START);
        busy_d        = (state_d == ST_START) || (state_d == ST_STREAM) || (state_d == ST_DRAIN);
        done_d        = (state_d == ST_DONE);
        valid_d       = rd_issue_s;
        if (rd_issue_s) begin
            phase_d = 2'(g_r_q);
            data0_d = bank_mem[2'd0][rd_addr_q];
            data1_d = bank_mem[2'd1][rd_addr_q];
            data2_d = bank_mem[2'd2][rd_addr_q];
            data3_d = bank_mem[2'd3][rd_addr_q];
        end else begin
            phase_d = 2'b00;
            data0_d = {FEAT_W{1'b0}};
            data1_d = {FEAT_W{1'b0}};
            data2_d = {FEAT_W{1'b0}};
            data3_d = {FEAT_W{1'b0}};
        end
    end

    // Bank write port: accepted word goes to bank ch[1:0] at row p*N_GRP + ch/4
    always_ff @(posedge iClk) begin
        if (wr_en_s) begin
            bank_mem[ch_w_q[1:0]][wr_addr_q] <= iInData;
        end
    end

    // State, counters and registered outputs; reset aborts any frame in flight
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q       <= ST_IDLE;
            ch_w_q        <= {CH_W{1'b0}};
            p_w_q         <= {POS_W{1'b0}};
            wr_addr_q     <= {ADDR_W{1'b0}};
            g_r_q         <= {G_W{1'b0}};
            p_r_q         <= {POS_W{1'b0}};
            rd_addr_q     <= {ADDR_W{1'b0}};
            in_ready_q    <= 1'b1;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            phase_q       <= 2'b00;
            data0_q       <= {FEAT_W{1'b0}};
            data1_q       <= {FEAT_W{1'b0}};
            data2_q       <= {FEAT_W{1'b0}};
            data3_q       <= {FEAT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            ch_w_q        <= ch_w_d;
            p_w_q         <= p_w_d;
            wr_addr_q     <= wr_addr_d;
            g_r_q         <= g_r_d;
            p_r_q         <= p_r_d;
            rd_addr_q     <= rd_addr_d;
            in_ready_q    <= in_ready_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            valid_q       <= valid_d;
            phase_q       <= phase_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            data3_q       <= data3_d;
        end
    end

    assign oInReady    = in_ready_q;
    assign oFrameStart = frame_start_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oValid4     = {4{valid_q}};
    assign oPhase_g    = phase_q;
    assign oData0      = data0_q;
    assign oData1      = data1_q;
    assign oData2      = data2_q;
    assign oData3      = data3_q;

endmodule

// File: tb/tb_fc_feat_streamer.sv
// Scoreboard bench for fc_feat_streamer. The reference model collects accepted words
// as a flat frame. When the frame completes, it schedules the frame-start pulse, the
// 676 beats and the done pulse by cycle number. A negedge monitor pops and compares
// each output event.
module tb_fc_feat_streamer;

    localparam int N_GRP = 4;
    localparam int TOTAL = 2704;
    localparam int BEATS = 676;
    localparam int SPAN  = 678;

    logic        iClk     = 1'b0;
    logic        iRstn    = 1'b1;
    logic        iInValid = 1'b0;
    logic [31:0] iInData  = 32'h0;
    logic        oInReady, oFrameStart, oBusy, oDone;
    logic [3:0]  oValid4;
    logic [31:0] oData0, oData1, oData2, oData3;
    logic [1:0]  oPhase_g;

    fc_feat_streamer #(.FEAT_W(32), .N_POS(169), .N_CH(16)) dut (
        .iClk(iClk), .iRstn(iRstn), .iInValid(iInValid), .iInData(iInData),
        .oInReady(oInReady), .oFrameStart(oFrameStart), .oValid4(oValid4),
        .oData0(oData0), .oData1(oData1), .oData2(oData2), .oData3(oData3),
        .oPhase_g(oPhase_g), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [3:0][31:0] d;
        logic [1:0]       ph;
        int               cyc;
    } beat_t;

    beat_t       beat_q[$];
    int          fs_q[$];
    int          done_q[$];
    logic [31:0] frame_m [TOTAL];
    int cyc = 0;
    int blk_m = 0;
    int fill_m = 0;
    int frames_m = 0;
    int last_w_m = 0;
    int fs_cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] gen(input int mode, input int idx);
        case (mode)
            0: gen = 32'd1;
            1: gen = (idx == 1000) ? 32'h8000_0000 : 32'(idx);
            2: gen = $urandom;
            default: gen = 32'h0001_0000 + 32'(idx);
        endcase
    endfunction

    // Reference model: a write is accepted whenever no frame is in flight.
    initial begin : model
        beat_t b;
        forever begin
            @(posedge iClk);
            if (iRstn) begin
                if (blk_m > 0) begin
                    blk_m = blk_m - 1;
                end else if (iInValid) begin
                    frame_m[fill_m] = iInData;
                    fill_m = fill_m + 1;
                    if (fill_m == TOTAL) begin
                        last_w_m = cyc;
                        fs_q.push_back(cyc + 1);
                        done_q.push_back(cyc + SPAN);
                        for (int k = 0; k < BEATS; k++) begin
                            for (int l = 0; l < 4; l++) b.d[l] = frame_m[4*k + l];
                            b.ph  = 2'(k % N_GRP);
                            b.cyc = cyc + 2 + k;
                            beat_q.push_back(b);
                        end
                        fill_m   = 0;
                        blk_m    = SPAN;
                        frames_m = frames_m + 1;
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: per-cycle status checks plus scoreboard pops on each output event.
    initial begin : monitor
        int    e;
        beat_t b;
        forever begin
            @(negedge iClk);
            if (iRstn) begin
                chk("in_ready", 64'(oInReady), 64'(blk_m == 0));
                chk("busy", 64'(oBusy), 64'(blk_m >= 2));
                if (oFrameStart) begin
                    if (fs_q.size() == 0) chk("frame_start_unexpected", 64'd1, 64'd0);
                    else begin
                        e = fs_q.pop_front();
                        chk("frame_start_cycle", 64'(cyc), 64'(e));
                        fs_cyc = cyc;
                    end
                end
                if (oDone) begin
                    if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                    else begin
                        e = done_q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(e));
                        chk("start_to_done_span", 64'(cyc - fs_cyc + 1), 64'(SPAN));
                    end
                end
                if (oValid4 != 4'b0000) begin
                    chk("valid4", 64'(oValid4), 64'hF);
                    if (beat_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
                    else begin
                        b = beat_q.pop_front();
                        chk("beat_cycle", 64'(cyc), 64'(b.cyc));
                        chk("lane0", 64'(oData0), 64'(b.d[0]));
                        chk("lane1", 64'(oData1), 64'(b.d[1]));
                        chk("lane2", 64'(oData2), 64'(b.d[2]));
                        chk("lane3", 64'(oData3), 64'(b.d[3]));
                        chk("phase", 64'(oPhase_g), 64'(b.ph));
                    end
                end else begin
                    chk("idle_lanes", 64'(oData0 | oData1 | oData2 | oData3), 64'd0);
                    chk("idle_phase", 64'(oPhase_g), 64'd0);
                end
            end
        end
    end

    task automatic do_reset();
        iRstn    = 1'b0;
        iInValid = 1'b0;
        blk_m    = 0;
        fill_m   = 0;
        beat_q.delete();
        fs_q.delete();
        done_q.delete();
        #1;
        chk("rst_in_ready", 64'(oInReady), 64'd1);
        chk("rst_frame_start", 64'(oFrameStart), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        chk("rst_done", 64'(oDone), 64'd0);
        chk("rst_valid4", 64'(oValid4), 64'd0);
        chk("rst_lanes", 64'(oData0 | oData1 | oData2 | oData3), 64'd0);
        chk("rst_phase", 64'(oPhase_g), 64'd0);
        repeat (3) @(negedge iClk);
        iRstn = 1'b1;
    endtask

    task automatic fill_frame(input int mode);
        int start_frames = frames_m;
        int guard = 0;
        while (frames_m == start_frames && guard < 20000) begin
            iInValid = ($urandom_range(0, 3) != 0);
            iInData  = gen(mode, fill_m);
            @(negedge iClk);
            guard++;
        end
        iInValid = 1'b0;
        iInData  = 32'h0;
        chk("fill_timeout", 64'(guard < 20000), 64'd1);
    endtask

    task automatic stream_wait(input bit junk);
        int guard = 0;
        while (blk_m != 0 && guard < 2000) begin
            if (junk) begin
                iInValid = 1'b1;
                iInData  = 32'hDEAD_BEEF;
            end else begin
                iInValid = 1'b0;
            end
            @(negedge iClk);
            guard++;
        end
        iInValid = 1'b0;
        iInData  = 32'h0;
        chk("stream_timeout", 64'(guard < 2000), 64'd1);
    endtask

    task automatic check_empty();
        chk("beats_missing", 64'(beat_q.size()), 64'd0);
        chk("frame_start_missing", 64'(fs_q.size()), 64'd0);
        chk("done_missing", 64'(done_q.size()), 64'd0);
    endtask

    initial begin : stim
        int g;
        #2;
        do_reset();
        // all-ones frame
        fill_frame(0); stream_wait(1'b0); check_empty();
        // mapping frame p*16+ch with one 32'h8000_0000 word
        fill_frame(1); stream_wait(1'b0); check_empty();
        // same mapping while junk words are offered during the stream
        fill_frame(1); stream_wait(1'b1); check_empty();
        // back-to-back refills with new data right after done
        fill_frame(3); stream_wait(1'b0); check_empty();
        fill_frame(2); stream_wait(1'b1); check_empty();
        // reset at beat 300, then a fresh mapping frame
        fill_frame(1);
        g = 0;
        while (cyc != last_w_m + 302 && g < 1000) begin
            @(negedge iClk);
            g++;
        end
        chk("reach_beat_300", 64'(g < 1000), 64'd1);
        do_reset();
        fill_frame(1); stream_wait(1'b0); check_empty();
        repeat (5) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
